// File: rtl/booth_seq_divider_if.sv
// Request/response bundle for the sequential signed divider.
interface booth_seq_divider_if #(parameter int N = 32);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] q;
  logic [N-1:0] r;
  logic         dz;

  modport master (output start, a, b, input busy, done, q, r, dz);
  modport slave  (input start, a, b, output busy, done, q, r, dz);
endinterface

// File: rtl/booth_seq_divider.sv
// Sequential signed divider: restoring division on magnitudes, one quotient bit
// per clock, then sign fix-up. Truncates toward zero like Verilog / and %.
module booth_seq_divider #(
  parameter int N = 32
) (
  input logic           clk,
  input logic           rst,
  booth_seq_divider_if.slave io
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  a_r;
  logic [N-1:0]  bm;
  logic [N-1:0]  d;
  logic [N-1:0]  p;
  logic          sign_q;
  logic          sign_r;
  logic          b_zero;

  logic [N-1:0]  a_abs, b_abs;
  logic [N:0]    p_sh;
  logic [N-1:0]  d_sh;
  logic [N-1:0]  p_nxt, d_nxt;

  // |min| wraps back to 2^(N-1), which is the correct unsigned magnitude.
  assign a_abs = io.a[N-1] ? -io.a : io.a;
  assign b_abs = io.b[N-1] ? -io.b : io.b;

  // The partial remainder stays below |b| <= 2^(N-1), so only the shifted
  // value needs the extra bit; the difference always fits in N bits.
  always_comb begin
    p_sh  = {p, d[N-1]};
    d_sh  = {d[N-2:0], 1'b0};
    p_nxt = p_sh[N-1:0];
    d_nxt = d_sh;
    if (p_sh >= {1'b0, bm}) begin
      p_nxt = p_sh[N-1:0] - bm;
      d_nxt = d_sh | {{(N-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      a_r     <= '0;
      bm      <= '0;
      d       <= '0;
      p       <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      b_zero  <= 1'b0;
      io.busy <= 1'b0;
      io.done <= 1'b0;
      io.q    <= '0;
      io.r    <= '0;
      io.dz   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io.start) begin
            a_r     <= io.a;
            bm      <= b_abs;
            d       <= a_abs;
            p       <= '0;
            sign_q  <= io.a[N-1] ^ io.b[N-1];
            sign_r  <= io.a[N-1];
            b_zero  <= (io.b == '0);
            cnt     <= CW'(N);
            io.busy <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          p   <= p_nxt;
          d   <= d_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          if (b_zero) begin
            io.q  <= '1;
            io.r  <= a_r;
            io.dz <= 1'b1;
          end else begin
            io.q  <= sign_q ? -d : d;
            io.r  <= sign_r ? -p : p;
            io.dz <= 1'b0;
          end
          io.busy <= 1'b0;
          io.done <= 1'b1;
          state   <= DONE;
        end
        default: begin
          io.done <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_booth_seq_divider.sv
// Randomized self-checking bench for booth_seq_divider against Verilog / and %.
module tb_booth_seq_divider;
  localparam int N   = 32;
  localparam int LAT = N + 2;

  logic clk;
  logic rst;
  int   checks;
  int   passed;

  booth_seq_divider_if #(.N(N)) io ();
  booth_seq_divider #(.N(N)) dut (.clk(clk), .rst(rst), .io(io.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void ref_div(input logic [N-1:0] a, input logic [N-1:0] b,
                                  output logic [N-1:0] q, output logic [N-1:0] r,
                                  output logic dz);
    if (b == '0) begin
      q = '1; r = a; dz = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = '0; dz = 1'b0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      dz = 1'b0;
    end
  endfunction

  // Drives one request; lat counts edges with the accepting edge as 1.
  task automatic run_op(input logic [N-1:0] ia, input logic [N-1:0] ib,
                        output logic [N-1:0] oq, output logic [N-1:0] orr,
                        output logic odz, output int lat);
    @(negedge clk);
    io.start = 1'b1; io.a = ia; io.b = ib;
    @(posedge clk); #1;
    io.start = 1'b0;
    lat = 1;
    while (io.done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    oq = io.q; orr = io.r; odz = io.dz;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; io.start = 1'b0; io.a = '0; io.b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (io.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", io.busy); else passed++;
    checks++; if (io.done !== 1'b0) $display("FAIL reset_done: got %b want 0", io.done); else passed++;
    checks++; if (io.q !== '0) $display("FAIL reset_q: got %h want 0", io.q); else passed++;
    checks++; if (io.r !== '0) $display("FAIL reset_r: got %h want 0", io.r); else passed++;
    checks++; if (io.dz !== 1'b0) $display("FAIL reset_dz: got %b want 0", io.dz); else passed++;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_basic;
    logic [N-1:0] q, r; logic dz; int lat;
    run_op(-32'sd15, 32'sd10, q, r, dz, lat);
    checks++; if (lat !== LAT) $display("FAIL basic_latency: got %0d want %0d", lat, LAT); else passed++;
    checks++; if (q !== 32'hFFFF_FFFF) $display("FAIL basic_q: got %h want ffffffff", q); else passed++;
    checks++; if (r !== 32'hFFFF_FFFB) $display("FAIL basic_r: got %h want fffffffb", r); else passed++;
    checks++; if (dz !== 1'b0) $display("FAIL basic_dz: got %b want 0", dz); else passed++;
  endtask

  task automatic test_signs;
    logic [N-1:0] ta [4] = '{32'd100, -32'sd100, 32'd100, -32'sd100};
    logic [N-1:0] tb [4] = '{32'd7, 32'd7, -32'sd7, -32'sd7};
    logic [N-1:0] tq [4] = '{32'd14, -32'sd14, -32'sd14, 32'd14};
    logic [N-1:0] tr [4] = '{32'd2, -32'sd2, 32'd2, -32'sd2};
    logic [N-1:0] q, r; logic dz; int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], q, r, dz, lat);
      checks++; if (q !== tq[i] || r !== tr[i])
        $display("FAIL signs_%0d: got q=%h r=%h want q=%h r=%h", i, q, r, tq[i], tr[i]); else passed++;
    end
  endtask

  task automatic test_div_zero;
    logic [N-1:0] q, r; logic dz; int lat;
    run_op(32'd37, 32'd0, q, r, dz, lat);
    checks++; if (lat !== LAT) $display("FAIL dz_latency: got %0d want %0d", lat, LAT); else passed++;
    checks++; if (q !== 32'hFFFF_FFFF || r !== 32'd37 || dz !== 1'b1)
      $display("FAIL dz_result: got q=%h r=%h dz=%b want q=ffffffff r=25 dz=1", q, r, dz); else passed++;
    run_op(32'd9, 32'd3, q, r, dz, lat);
    checks++; if (q !== 32'd3 || r !== 32'd0 || dz !== 1'b0)
      $display("FAIL dz_next: got q=%h r=%h dz=%b want q=3 r=0 dz=0", q, r, dz); else passed++;
  endtask

  task automatic test_corners;
    logic [N-1:0] cv [7] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                             32'h8000_0001, 32'h8000_0000, 32'd2};
    logic [N-1:0] q, r, eq, er; logic dz, edz; int lat;
    run_op(32'h8000_0000, 32'hFFFF_FFFF, q, r, dz, lat);
    checks++; if (q !== 32'h8000_0000 || r !== '0 || dz !== 1'b0)
      $display("FAIL overflow: got q=%h r=%h dz=%b want q=80000000 r=0 dz=0", q, r, dz); else passed++;
    run_op(32'h7FFF_FFFF, 32'd1, q, r, dz, lat);
    checks++; if (q !== 32'h7FFF_FFFF || r !== '0)
      $display("FAIL max_by_one: got q=%h r=%h want q=7fffffff r=0", q, r); else passed++;
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7; j++) begin
        run_op(cv[i], cv[j], q, r, dz, lat);
        ref_div(cv[i], cv[j], eq, er, edz);
        checks++; if (q !== eq || r !== er || dz !== edz || lat !== LAT)
          $display("FAIL corner %h/%h: got q=%h r=%h dz=%b lat=%0d want q=%h r=%h dz=%b lat=%0d",
                   cv[i], cv[j], q, r, dz, lat, eq, er, edz, LAT); else passed++;
      end
  endtask

  task automatic test_restart_ignored;
    int ndone = 0;
    int busy_bad = 0;
    @(negedge clk);
    io.start = 1'b1; io.a = 32'd100; io.b = 32'd7;
    @(posedge clk); #1;
    io.start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (io.busy !== ((k <= 33) ? 1'b1 : 1'b0)) begin
        busy_bad++;
        $display("FAIL restart_busy cycle %0d: got %b want %b", k, io.busy, (k <= 33));
      end
      if (io.done === 1'b1) ndone++;
      io.start = (k == 5 || k == 20);
      io.a = 32'd1; io.b = 32'd1;
      @(posedge clk); #1;
    end
    io.start = 1'b0;
    checks++; if (busy_bad != 0) $display("FAIL restart_busy_total: got %0d bad cycles want 0", busy_bad); else passed++;
    checks++; if (ndone != 1) $display("FAIL restart_done_count: got %0d want 1", ndone); else passed++;
    checks++; if (io.q !== 32'd14 || io.r !== 32'd2)
      $display("FAIL restart_result: got q=%h r=%h want q=e r=2", io.q, io.r); else passed++;
  endtask

  task automatic test_reset_mid;
    logic [N-1:0] q, r; logic dz; int lat;
    int seen_done = 0;
    @(negedge clk);
    io.start = 1'b1; io.a = 32'd100; io.b = 32'd7;
    @(posedge clk); #1;
    io.start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (io.busy !== 1'b0 || io.done !== 1'b0 || io.q !== '0 || io.r !== '0 || io.dz !== 1'b0)
      $display("FAIL midreset_async: got busy=%b done=%b q=%h r=%h dz=%b want all 0",
               io.busy, io.done, io.q, io.r, io.dz); else passed++;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (io.done === 1'b1) seen_done++;
      if (k == 3) rst = 1'b1;
    end
    checks++; if (seen_done != 0) $display("FAIL midreset_no_done: got %0d pulses want 0", seen_done); else passed++;
    rst = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    run_op(32'd50, 32'd5, q, r, dz, lat);
    checks++; if (lat !== LAT || q !== 32'd10 || r !== '0 || dz !== 1'b0)
      $display("FAIL midreset_after: got lat=%0d q=%h r=%h dz=%b want lat=%0d q=a r=0 dz=0",
               lat, q, r, dz, LAT); else passed++;
  endtask

  task automatic test_random;
    logic [N-1:0] a, b, q, r, eq, er; logic dz, edz; int lat;
    for (int i = 0; i < 1500; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) b = -b;
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
      run_op(a, b, q, r, dz, lat);
      ref_div(a, b, eq, er, edz);
      checks++; if (q !== eq || r !== er || dz !== edz || lat !== LAT)
        $display("FAIL random %h/%h: got q=%h r=%h dz=%b lat=%0d want q=%h r=%h dz=%b lat=%0d",
                 a, b, q, r, dz, lat, eq, er, edz, LAT); else passed++;
    end
  endtask

  initial begin
    checks = 0; passed = 0;
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_corners();
    test_restart_ignored();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
